// File: rtl/vita49_tsfclk_pkg.sv
// vita49_tsfclk_pkg: ctrl bit map, state and error encodings shared by the tsfclk blocks
package vita49_tsfclk_pkg;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RST    = 1;
  localparam int CTRL_LOAD   = 2;
  localparam int CTRL_CH0    = 5;
  localparam int CTRL_CH1    = 6;
  localparam int CTRL_HWS    = 7;
  localparam int CTRL_HWS_OR = 8;
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RST    = 4'd1,
    ST_GAP1   = 4'd2,
    ST_LOAD   = 4'd3,
    ST_GAP2   = 4'd4,
    ST_RUN    = 4'd5,
    ST_ARM    = 4'd6,
    ST_LOCKED = 4'd7,
    ST_FAULT  = 4'd8
  } state_t;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_CFG     = 2'b10;
  function automatic logic [31:0] run_word(logic [1:0] mask, logic hws, logic sor);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN]     = 1'b1;
    w[CTRL_CH0]    = mask[0];
    w[CTRL_CH1]    = mask[1];
    w[CTRL_HWS]    = hws;
    w[CTRL_HWS_OR] = hws & sor;
    return w;
  endfunction
endpackage

// File: rtl/vita49_tsfclk_seq_if.sv
// vita49_tsfclk_seq_if: register-block side command, config and status of the sequencer
interface vita49_tsfclk_seq_if #(parameter int CNT_W = 16);
  logic             start;
  logic             abort;
  logic [1:0]       cfg_ch_mask;
  logic             cfg_hw_sync;
  logic             cfg_sync_or;
  logic [31:0]      cfg_timeout;
  logic             busy;
  logic             locked;
  logic [1:0]       err_code;
  logic [3:0]       state;
  logic [CNT_W-1:0] sync_cnt;
  modport master(output start, abort, cfg_ch_mask, cfg_hw_sync, cfg_sync_or, cfg_timeout,
                 input busy, locked, err_code, state, sync_cnt);
  modport slave(input start, abort, cfg_ch_mask, cfg_hw_sync, cfg_sync_or, cfg_timeout,
                output busy, locked, err_code, state, sync_cnt);
endinterface

// File: rtl/vita49_sync_edge.sv
// vita49_sync_edge: 2-flop synchronizer followed by a one-cycle rising-edge pulse
module vita49_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);
  logic [2:0] sh;
  always_ff @(posedge clk)
    if (rst) sh <= '0;
    else sh <= {sh[1:0], sig};
  assign pulse = sh[1] & ~sh[2];
endmodule

// File: rtl/vita49_tsfclk_seq.sv
// vita49_tsfclk_seq: bring-up sequencer owning the vita49_tsfclk_logic ctrl word
module vita49_tsfclk_seq
  import vita49_tsfclk_pkg::*;
#(
  parameter int PULSE_CYC  = 4,
  parameter int GAP_CYC    = 4,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 16
) (
  input  logic                axi_clk,
  input  logic                axi_reset,
  vita49_tsfclk_seq_if.slave  bus,
  input  logic                sync0,
  input  logic                sync1,
  output logic [31:0]         ctrl_out
);
  state_t st, st_nx;
  logic [31:0] cnt, limit, tmo, ctrl_nx;
  logic [1:0] mask, seen, seen_nx, pulse, err;
  logic hws, sor, go, done, lock, tout;
  logic [CNT_W-1:0] sync_cnt;
  vita49_sync_edge u_sync0 (.clk(axi_clk), .rst(axi_reset), .sig(sync0), .pulse(pulse[0]));
  vita49_sync_edge u_sync1 (.clk(axi_clk), .rst(axi_reset), .sig(sync1), .pulse(pulse[1]));
  always_comb begin
    go = bus.start & ~bus.abort & (st inside {ST_IDLE, ST_LOCKED, ST_FAULT});
    limit = (st inside {ST_RST, ST_LOAD}) ? 32'(PULSE_CYC - 1) :
            (st inside {ST_GAP1, ST_GAP2}) ? 32'(GAP_CYC - 1) : 32'(SETTLE_CYC - 1);
    done = cnt == limit;
    // the pulse of this cycle counts, so a lock coinciding with the timeout still wins
    seen_nx = seen | (pulse & mask);
    lock = sor ? |seen_nx : seen_nx == mask;
    tout = tmo != '0 && cnt == tmo - 32'd1;
    st_nx = st;
    if (bus.abort) st_nx = ST_IDLE;
    else if (go) st_nx = bus.cfg_ch_mask == 2'b00 ? ST_FAULT : ST_RST;
    else case (st)
      ST_RST:  if (done) st_nx = ST_GAP1;
      ST_GAP1: if (done) st_nx = ST_LOAD;
      ST_LOAD: if (done) st_nx = ST_GAP2;
      ST_GAP2: if (done) st_nx = ST_RUN;
      ST_RUN:  if (done) st_nx = hws ? ST_ARM : ST_LOCKED;
      ST_ARM:  st_nx = lock ? ST_LOCKED : tout ? ST_FAULT : ST_ARM;
      default: st_nx = st;
    endcase
    ctrl_nx = (st_nx == ST_RST) ? 32'd1 << CTRL_RST :
              (st_nx == ST_LOAD) ? 32'd1 << CTRL_LOAD :
              (st_nx == ST_RUN) ? run_word(mask, 1'b0, 1'b0) :
              (st_nx inside {ST_ARM, ST_LOCKED}) ? run_word(mask, hws, sor) : '0;
  end
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      st <= ST_IDLE;
      cnt <= '0;
      ctrl_out <= '0;
      seen <= '0;
      mask <= '0;
      hws <= 1'b0;
      sor <= 1'b0;
      tmo <= '0;
      err <= ERR_NONE;
      sync_cnt <= '0;
    end else begin
      st <= st_nx;
      ctrl_out <= ctrl_nx;
      cnt <= st_nx != st ? '0 : cnt + 32'd1;
      seen <= st == ST_ARM ? seen_nx : 2'b00;
      err <= bus.abort ? ERR_NONE :
             go ? (bus.cfg_ch_mask == 2'b00 ? ERR_CFG : ERR_NONE) :
             (st == ST_ARM && st_nx == ST_FAULT) ? ERR_TIMEOUT : err;
      if (go) begin
        mask <= bus.cfg_ch_mask;
        hws <= bus.cfg_hw_sync;
        sor <= bus.cfg_sync_or;
        tmo <= bus.cfg_timeout;
        sync_cnt <= '0;
      end else if (st == ST_LOCKED && pulse[0] && ~&sync_cnt) sync_cnt <= sync_cnt + 1'b1;
    end
  end
  assign bus.busy = st inside {ST_RST, ST_GAP1, ST_LOAD, ST_GAP2, ST_RUN, ST_ARM};
  assign bus.locked = st == ST_LOCKED;
  assign bus.err_code = err;
  assign bus.state = st;
  assign bus.sync_cnt = sync_cnt;
endmodule

// File: tb/tb_vita49_tsfclk_seq.sv
// tb_vita49_tsfclk_seq: table, hand-written and randomized checks of the bring-up sequencer
module tb_vita49_tsfclk_seq;
  localparam int PULSE = 4, GAP = 4, SETTLE = 16;
  logic axi_clk = 1'b0, axi_reset = 1'b1, sync0 = 1'b0, sync1 = 1'b0;
  logic [31:0] ctrl_out;
  int vectors = 0, miscompares = 0;
  vita49_tsfclk_seq_if #(.CNT_W(16)) bus ();
  vita49_tsfclk_seq #(.PULSE_CYC(PULSE), .GAP_CYC(GAP), .SETTLE_CYC(SETTLE), .CNT_W(16)) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset), .bus(bus), .sync0(sync0), .sync1(sync1), .ctrl_out(ctrl_out));
  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic [1:0] m; bit h; bit o; int t; int d0; int d1; int stop; bit lk; logic [31:0] ctl; logic [1:0] err;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(negedge axi_clk);
  endtask

  // ctrl word straight from the bit map: EN, channel mask at 5, HW sync at 7, OR mode at 8
  function automatic logic [31:0] word(logic [1:0] m, bit h, bit o);
    return 32'h1 | (32'(m) << 5) | (32'(h) << 7) | (32'(h & o) << 8);
  endfunction

  // cycles after ARM entry until LOCKED/FAULT shows: a sync raised in cycle d is seen at d+3
  function automatic int outcome(logic [1:0] m, bit o, int t, int d0, int d1, output bit lk);
    int t0, t1, need;
    t0 = d0 < 0 ? 1 << 30 : d0 + 3;
    t1 = d1 < 0 ? 1 << 30 : d1 + 3;
    need = m == 2'b01 ? t0 : m == 2'b10 ? t1 : o ? (t0 < t1 ? t0 : t1) : (t0 > t1 ? t0 : t1);
    lk = !(t != 0 && need > t);
    return lk ? need : t;
  endfunction

  task automatic go_cmd(input logic [1:0] m, input bit h, input bit o, input int t);
    bus.cfg_ch_mask = m; bus.cfg_hw_sync = h; bus.cfg_sync_or = o; bus.cfg_timeout = t;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    bus.cfg_ch_mask = ~m; bus.cfg_hw_sync = ~h; bus.cfg_sync_or = ~o; bus.cfg_timeout = 32'd3;
  endtask

  task automatic abort_cmd();
    bus.abort = 1'b1; cyc(); bus.abort = 1'b0;
    check("abort_state", 32'(bus.state), 32'd0);
    check("abort_ctrl", ctrl_out, 32'd0);
    check("abort_err", 32'(bus.err_code), 32'd0);
  endtask

  task automatic bringup(input logic [1:0] m, input bit h, input bit o, input int t, input int start_at, input int sync_at);
    int lens[5] = '{PULSE, GAP, PULSE, GAP, SETTLE};
    int sts[5] = '{1, 2, 3, 4, 5};
    logic [31:0] ctl[5];
    int idx = 0;
    ctl = '{32'h2, 32'h0, 32'h4, 32'h0, word(m, 1'b0, 1'b0)};
    go_cmd(m, h, o, t);
    for (int p = 0; p < 5; p++)
      for (int j = 0; j < lens[p]; j++) begin
        check("seq_state", 32'(bus.state), 32'(sts[p]));
        check("seq_ctrl", ctrl_out, ctl[p]);
        check("seq_busy", 32'(bus.busy), 32'd1);
        if (idx == 0) check("seq_err_clr", 32'(bus.err_code), 32'd0);
        bus.start = idx == start_at;
        sync0 = sync_at >= 0 && (idx == sync_at || idx == sync_at + 1);
        cyc();
        idx++;
      end
    bus.start = 1'b0;
    sync0 = 1'b0;
  endtask

  task automatic arm_phase(input int d0, input int d1, input int stop, input bit lk,
                           input logic [31:0] armw, input logic [31:0] fin, input logic [1:0] err);
    for (int c = 0; c <= stop; c++) begin
      if (c < stop) begin
        check("arm_state", 32'(bus.state), 32'd6);
        if (c == 0) check("arm_ctrl", ctrl_out, armw);
      end else begin
        check("final_state", 32'(bus.state), lk ? 32'd7 : 32'd8);
        check("final_ctrl", ctrl_out, fin);
        check("final_err", 32'(bus.err_code), 32'(err));
        check("final_locked", 32'(bus.locked), 32'(lk));
        check("final_busy", 32'(bus.busy), 32'd0);
      end
      sync0 = d0 >= 0 && (c == d0 || c == d0 + 1);
      sync1 = d1 >= 0 && (c == d1 || c == d1 + 1);
      cyc();
    end
    sync0 = 1'b0;
    sync1 = 1'b0;
    repeat (5) cyc();
  endtask

  initial begin
    tbl[0] = '{2'b01, 1'b0, 1'b0, 0,   -1, -1, 0,   1'b1, 32'h021, 2'b00};
    tbl[1] = '{2'b01, 1'b1, 1'b0, 0,   50, -1, 53,  1'b1, 32'h0A1, 2'b00};
    tbl[2] = '{2'b11, 1'b1, 1'b0, 0,   10, 40, 43,  1'b1, 32'h0E1, 2'b00};
    tbl[3] = '{2'b11, 1'b1, 1'b1, 0,   10, -1, 13,  1'b1, 32'h1E1, 2'b00};
    tbl[4] = '{2'b01, 1'b1, 1'b0, 100, -1, -1, 100, 1'b0, 32'h000, 2'b01};
    tbl[5] = '{2'b01, 1'b1, 1'b0, 100, 97, -1, 100, 1'b1, 32'h0A1, 2'b00};
    tbl[6] = '{2'b01, 1'b1, 1'b0, 100, 98, -1, 100, 1'b0, 32'h000, 2'b01};
    tbl[7] = '{2'b10, 1'b1, 1'b1, 30,  5,  -1, 30,  1'b0, 32'h000, 2'b01};
    tbl[8] = '{2'b10, 1'b1, 1'b0, 0,   -1, 7,  10,  1'b1, 32'h0C1, 2'b00};
    tbl[9] = '{2'b11, 1'b1, 1'b0, 50,  5,  60, 50,  1'b0, 32'h000, 2'b01};
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.cfg_ch_mask = 2'b01; bus.cfg_hw_sync = 1'b0; bus.cfg_sync_or = 1'b0; bus.cfg_timeout = 0;
    repeat (2) cyc();
    check("rst_ctrl", ctrl_out, 32'd0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_err", 32'(bus.err_code), 32'd0);
    check("rst_sync_cnt", 32'(bus.sync_cnt), 32'd0);
    axi_reset = 1'b0;
    cyc();
    check("idle_state", 32'(bus.state), 32'd0);

    for (int i = 0; i < 10; i++) begin
      abort_cmd();
      bringup(tbl[i].m, tbl[i].h, tbl[i].o, tbl[i].t, -1, -1);
      arm_phase(tbl[i].d0, tbl[i].d1, tbl[i].stop, tbl[i].lk, word(tbl[i].m, tbl[i].h, tbl[i].o), tbl[i].ctl, tbl[i].err);
    end

    // five sync0 edges while locked, then abort
    abort_cmd();
    bringup(2'b01, 1'b0, 1'b0, 0, -1, -1);
    arm_phase(-1, -1, 0, 1'b1, 32'h0, 32'h021, 2'b00);
    check("cnt_zero", 32'(bus.sync_cnt), 32'd0);
    repeat (5) begin
      sync0 = 1'b1; repeat (2) cyc();
      sync0 = 1'b0; repeat (3) cyc();
    end
    repeat (3) cyc();
    check("cnt_five", 32'(bus.sync_cnt), 32'd5);
    check("cnt_locked", 32'(bus.locked), 32'd1);
    abort_cmd();
    check("abort_locked", 32'(bus.locked), 32'd0);

    // empty channel mask faults without any RST pulse
    go_cmd(2'b00, 1'b0, 1'b0, 0);
    check("cfg_state", 32'(bus.state), 32'd8);
    check("cfg_err", 32'(bus.err_code), 32'd2);
    check("cfg_busy", 32'(bus.busy), 32'd0);
    repeat (4) begin
      check("cfg_no_rst", ctrl_out, 32'd0);
      cyc();
    end

    // start during LOAD is ignored; sync0 during RUN is ignored
    abort_cmd();
    bringup(2'b01, 1'b0, 1'b0, 0, 9, -1);
    arm_phase(-1, -1, 0, 1'b1, 32'h0, 32'h021, 2'b00);
    abort_cmd();
    bringup(2'b01, 1'b1, 1'b0, 30, -1, 20);
    arm_phase(-1, -1, 30, 1'b0, 32'h0A1, 32'h0, 2'b01);

    // start and abort together from LOCKED
    bringup(2'b01, 1'b0, 1'b0, 0, -1, -1);
    arm_phase(-1, -1, 0, 1'b1, 32'h0, 32'h021, 2'b00);
    bus.cfg_ch_mask = 2'b01; bus.start = 1'b1; bus.abort = 1'b1;
    cyc();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("both_state", 32'(bus.state), 32'd0);
    check("both_ctrl", ctrl_out, 32'd0);
    cyc();
    check("both_stay", 32'(bus.state), 32'd0);

    // abort in RST, then reset in RUN
    go_cmd(2'b01, 1'b0, 1'b0, 0);
    repeat (2) cyc();
    check("mid_rst_ctrl", ctrl_out, 32'h2);
    abort_cmd();
    go_cmd(2'b11, 1'b1, 1'b1, 0);
    repeat (2 * PULSE + 2 * GAP + 3) cyc();
    check("mid_run_state", 32'(bus.state), 32'd5);
    check("mid_run_ctrl", ctrl_out, 32'h061);
    axi_reset = 1'b1;
    cyc();
    check("reset_run_ctrl", ctrl_out, 32'd0);
    check("reset_run_state", 32'(bus.state), 32'd0);
    check("reset_run_busy", 32'(bus.busy), 32'd0);
    check("reset_run_err", 32'(bus.err_code), 32'd0);
    axi_reset = 1'b0;
    repeat (3) cyc();

    for (int n = 0; n < 20; n++) begin
      logic [1:0] m;
      bit h, o, lk;
      int t, d0, d1, stop;
      m = 2'($urandom_range(1, 3));
      h = $urandom_range(0, 4) != 0;
      o = 1'($urandom_range(0, 1));
      t = int'($urandom_range(20, 80));
      d0 = $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 90));
      d1 = $urandom_range(0, 3) == 0 ? -1 : int'($urandom_range(0, 90));
      stop = outcome(m, o, t, d0, d1, lk);
      if (!h) begin stop = 0; lk = 1'b1; end
      bringup(m, h, o, t, -1, -1);
      arm_phase(d0, d1, stop, lk, word(m, h, o), lk ? word(m, h, o) : 32'h0, lk ? 2'b00 : 2'b01);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
